// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU retirement trace FIFO: record layout, kinds,
// FSM states and defaults.
package cpu_trace_pkg;

  localparam int unsigned REC_W         = 16;
  localparam int unsigned SEQ_W         = 3;
  localparam int unsigned DEFAULT_DEPTH = 8;

  localparam int unsigned SEQ_LSB  = 13;
  localparam int unsigned KIND_BIT = 12;
  localparam int unsigned PC_LSB   = 8;
  localparam int unsigned DEST_LSB = 4;
  localparam int unsigned DATA_LSB = 0;

  localparam logic KIND_REG = 1'b0;
  localparam logic KIND_MEM = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STOPPED = 2'd2
  } traceState_t;

  function automatic logic [REC_W-1:0] packRecord(
    input logic [SEQ_W-1:0] seq,
    input logic             kind,
    input logic [3:0]       pc,
    input logic [3:0]       dest,
    input logic [3:0]       data
  );
    logic [REC_W-1:0] rec;
    rec                      = '0;
    rec[SEQ_LSB +: SEQ_W]    = seq;
    rec[KIND_BIT]            = kind;
    rec[PC_LSB +: 4]         = pc;
    rec[DEST_LSB +: 4]       = dest;
    rec[DATA_LSB +: 4]       = data;
    return rec;
  endfunction

endpackage

// File: rtl/cpu_trace_fifo_mem.sv
// First-word fall-through storage for trace records; a push into a full FIFO
// is accepted only when a pop frees a slot on the same edge.
module trace_fifo_mem
  import cpu_trace_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [REC_W-1:0] dataIn,
  output logic [REC_W-1:0] dataOut,
  output logic [4:0]       count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [REC_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             isEmpty;
  logic             isFull;
  logic             doPush;
  logic             doPop;

  assign isEmpty = (count == '0);
  assign isFull  = (count == 5'(DEPTH));
  assign doPop   = pop && !isEmpty;
  assign doPush  = push && (!isFull || doPop);

  // Gated to zero when empty so reset forces the head to zero without clearing the array.
  assign dataOut = isEmpty ? '0 : mem[rdPtr];

  always_ff @(posedge clock) begin
    if (doPush) begin
      mem[wrPtr] <= dataIn;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cpu_trace_fifo.sv
// Captures retiring CPU register/memory writes as 16-bit trace records with a
// sequence number, an overflow counter and an optional stop-on-overflow mode.
module cpu_trace_fifo
  import cpu_trace_pkg::*;
#(
  parameter int unsigned DEPTH       = DEFAULT_DEPTH,
  parameter bit          STOP_ON_OVF = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  PC,
  input  logic        RegWrite,
  input  logic        MemWrite,
  input  logic [1:0]  addrRz,
  input  logic [3:0]  outDataMux,
  input  logic [3:0]  aluResult,
  input  logic [3:0]  Ry,
  input  logic        trace_ready,
  output logic        trace_valid,
  output logic [15:0] trace_data,
  output logic [4:0]  count,
  output logic        full,
  output logic        empty,
  output logic [7:0]  ovf_cnt,
  output logic        stopped
);

  traceState_t      state;
  logic [SEQ_W-1:0] seq;
  logic             capture;
  logic             popReq;
  logic             drop;
  logic [3:0]       dest;
  logic [3:0]       data;
  logic [REC_W-1:0] record;

  assign empty       = (count == '0);
  assign full        = (count == 5'(DEPTH));
  assign trace_valid = !empty;
  assign popReq      = trace_valid && trace_ready;
  assign capture     = (state == ST_RUN) && (RegWrite || MemWrite);
  assign drop        = capture && full && !popReq;

  // A memory write wins when both strobes are high.
  always_comb begin
    dest   = MemWrite ? aluResult : {2'b00, addrRz};
    data   = MemWrite ? Ry : outDataMux;
    record = packRecord(seq, MemWrite ? KIND_MEM : KIND_REG, PC, dest, data);
  end

  trace_fifo_mem #(
    .DEPTH(DEPTH)
  ) uMem (
    .clock  (clock),
    .reset  (reset),
    .push   (capture),
    .pop    (popReq),
    .dataIn (record),
    .dataOut(trace_data),
    .count  (count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      seq     <= '0;
      ovf_cnt <= '0;
      stopped <= 1'b0;
    end else begin
      if (capture) begin
        seq <= seq + 1'b1;
      end
      if (drop && (ovf_cnt != 8'hFF)) begin
        ovf_cnt <= ovf_cnt + 8'd1;
      end
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state   <= ST_IDLE;
            stopped <= 1'b0;
          end else if (drop && STOP_ON_OVF) begin
            state   <= ST_STOPPED;
            stopped <= 1'b1;
          end
        end
        ST_STOPPED: begin
          if (!enable) begin
            state   <= ST_IDLE;
            stopped <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          stopped <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_trace_fifo.sv
// Scoreboard bench for cpu_trace_fifo: two instances (normal and stop-on-overflow)
// share stimulus; a queue-based reference model predicts records and flags.
module tb_cpu_trace_fifo;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  PC = '0;
  logic        RegWrite = 1'b0;
  logic        MemWrite = 1'b0;
  logic [1:0]  addrRz = '0;
  logic [3:0]  outDataMux = '0;
  logic [3:0]  aluResult = '0;
  logic [3:0]  Ry = '0;
  logic        trace_ready = 1'b0;

  logic        v0, v1, fl0, fl1, em0, em1, st0, st1;
  logic [15:0] d0, d1;
  logic [4:0]  c0, c1;
  logic [7:0]  o0, o1;

  int checks = 0;
  int errors = 0;

  logic [15:0] expQ0[$];
  logic [15:0] expQ1[$];
  int mocc[2];
  int mseq[2];
  int movf[2];
  bit armed[2];
  bit halted[2];

  cpu_trace_fifo #(.DEPTH(DEPTH), .STOP_ON_OVF(1'b0)) dut0 (
    .clock(clock), .reset(reset), .enable(enable), .PC(PC), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .addrRz(addrRz), .outDataMux(outDataMux), .aluResult(aluResult),
    .Ry(Ry), .trace_ready(trace_ready), .trace_valid(v0), .trace_data(d0), .count(c0),
    .full(fl0), .empty(em0), .ovf_cnt(o0), .stopped(st0)
  );

  cpu_trace_fifo #(.DEPTH(DEPTH), .STOP_ON_OVF(1'b1)) dut1 (
    .clock(clock), .reset(reset), .enable(enable), .PC(PC), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .addrRz(addrRz), .outDataMux(outDataMux), .aluResult(aluResult),
    .Ry(Ry), .trace_ready(trace_ready), .trace_valid(v1), .trace_data(d1), .count(c1),
    .full(fl1), .empty(em1), .ovf_cnt(o1), .stopped(st1)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    expQ0.delete();
    expQ1.delete();
    for (int k = 0; k < 2; k++) begin
      mocc[k] = 0; mseq[k] = 0; movf[k] = 0; armed[k] = 0; halted[k] = 0;
    end
  endtask

  // Predicts the effect of the coming rising edge from the inputs now applied.
  task automatic modelEdge(input int k);
    bit cap, pop, drp, isMem;
    int dest, data, rec;
    cap = armed[k] && (RegWrite || MemWrite);
    pop = (mocc[k] > 0) && trace_ready;
    drp = 0;
    if (cap) begin
      isMem = MemWrite;
      dest  = isMem ? int'(aluResult) : int'(addrRz);
      data  = isMem ? int'(Ry) : int'(outDataMux);
      rec   = (mseq[k] % 8) * 8192 + int'(isMem) * 4096 + int'(PC) * 256 + dest * 16 + data;
      if (mocc[k] == DEPTH && !pop) begin
        drp = 1;
        if (movf[k] < 255) movf[k]++;
      end else begin
        if (k == 0) expQ0.push_back(16'(rec));
        else        expQ1.push_back(16'(rec));
        mocc[k]++;
      end
      mseq[k]++;
    end
    if (pop) mocc[k]--;
    if (halted[k]) begin
      if (!enable) halted[k] = 0;
    end else if (armed[k]) begin
      if (!enable) armed[k] = 0;
      else if (drp && k == 1) begin
        armed[k]  = 0;
        halted[k] = 1;
      end
    end else if (enable) begin
      armed[k] = 1;
    end
  endtask

  task automatic checkDut(input string tag, input int k, input logic vv, input logic [4:0] cc,
                          input logic ff, input logic ee, input logic [7:0] oo, input logic ss);
    chk({tag, "_count"}, cc, mocc[k]);
    chk({tag, "_full"}, ff, mocc[k] == DEPTH);
    chk({tag, "_empty"}, ee, mocc[k] == 0);
    chk({tag, "_valid"}, vv, mocc[k] != 0);
    chk({tag, "_ovf"}, oo, movf[k]);
    chk({tag, "_stopped"}, ss, halted[k]);
  endtask

  task automatic checkAll();
    checkDut("dut0", 0, v0, c0, fl0, em0, o0, st0);
    checkDut("dut1", 1, v1, c1, fl1, em1, o1, st1);
  endtask

  task automatic step();
    modelEdge(0);
    modelEdge(1);
    @(posedge clock);
    #1;
    checkAll();
  endtask

  task automatic setEvent(input logic rw, input logic mw);
    RegWrite   = rw;
    MemWrite   = mw;
    PC         = 4'($urandom);
    addrRz     = 2'($urandom);
    outDataMux = 4'($urandom);
    aluResult  = 4'($urandom);
    Ry         = 4'($urandom);
  endtask

  task automatic checkResetValues();
    checkAll();
    chk("rst_data0", d0, 0);
    chk("rst_data1", d1, 0);
  endtask

  task automatic releaseReset();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: whenever a head record is presented it must be the oldest expected one.
  always @(negedge clock) begin
    if (v0) begin
      if (expQ0.size() == 0) chk("head0_expected", 1, 0);
      else begin
        chk("head0", d0, expQ0[0]);
        if (trace_ready) void'(expQ0.pop_front());
      end
    end
    if (v1) begin
      if (expQ1.size() == 0) chk("head1_expected", 1, 0);
      else begin
        chk("head1", d1, expQ1[0]);
        if (trace_ready) void'(expQ1.pop_front());
      end
    end
  end

  initial begin
    modelReset();
    #3;
    checkResetValues();
    releaseReset();

    // Single register record, then a combined reg+mem write.
    enable = 1'b1;
    step();
    RegWrite = 1'b1; MemWrite = 1'b0; PC = 4'h3; addrRz = 2'd2; outDataMux = 4'h9;
    step();
    chk("req038_data", d0, 16'h0329);
    RegWrite = 1'b1; MemWrite = 1'b1; PC = 4'h7; aluResult = 4'h5; Ry = 4'hA;
    step();
    chk("req039_count", c0, 2);
    RegWrite = 1'b0; MemWrite = 1'b0; trace_ready = 1'b1;
    step();
    chk("req039_data", d0, 16'h375A);
    trace_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      setEvent(1'b1, 1'b0);
      step();
    end
    chk("pre_rst_count", c0, 5);

    // Asynchronous reset between edges.
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    checkResetValues();
    setEvent(1'b0, 1'b0);
    releaseReset();

    // Ten captures into a non-draining FIFO.
    enable = 1'b1;
    trace_ready = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      setEvent(1'b1, 1'($urandom));
      step();
    end
    chk("req040_count", c0, 8);
    chk("req040_full", fl0, 1);
    chk("req040_ovf", o0, 2);
    chk("req040_headseq", d0[15:13], 0);
    chk("req042_stopped", st1, 1);
    chk("req042_ovf", o1, 1);

    // Capture while full with a simultaneous pop.
    trace_ready = 1'b1;
    setEvent(1'b1, 1'b0);
    step();
    chk("req041_count", c0, 8);
    chk("req041_ovf", o0, 2);

    setEvent(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step();
    chk("drain_empty", em0, 1);

    enable = 1'b0;
    step();
    chk("req042_unstop", st1, 0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      enable      = ($urandom_range(0, 31) != 0);
      trace_ready = ($urandom_range(0, 3) != 0) ^ (i % 200 < 60);
      setEvent(1'($urandom), 1'($urandom_range(0, 2) == 0));
      step();
    end

    // Overflow counter saturation.
    enable = 1'b1;
    trace_ready = 1'b0;
    setEvent(1'b0, 1'b0);
    step();
    step();
    for (int i = 0; i < 275; i++) begin
      setEvent(1'b1, 1'($urandom));
      step();
    end
    chk("ovf_saturate", o0, 255);
    setEvent(1'b0, 1'b0);
    trace_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("final_q0", expQ0.size(), 0);
    chk("final_q1", expQ1.size(), 0);

    #2;
    reset = 1'b0;
    modelReset();
    #1;
    checkResetValues();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_trace_fifo.md
CPU_TRACE_FIFO -- requirements
Module: cpu_trace_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries (power of two, 4..16).
REQ-002 Parameter STOP_ON_OVF, default 0; when 1, capture halts on the first overflow.
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low: asserted when 0; clears all state immediately.
REQ-005 enable  input  1  arms capture while high.
REQ-006 PC  input  4  CPU program counter of the retiring instruction.
REQ-007 RegWrite  input  1  CPU register write strobe.
REQ-008 MemWrite  input  1  CPU data-memory write strobe.
REQ-009 addrRz  input  2  destination register index.
REQ-010 outDataMux  input  4  register writeback data.
REQ-011 aluResult  input  4  data-memory address.
REQ-012 Ry  input  4  data-memory write data.
REQ-013 trace_ready  input  1  consumer accepts the head record.
REQ-014 trace_valid  output  1  head record present.
REQ-015 trace_data  output  16  head record.
REQ-016 count  output  5  occupancy, 0..DEPTH.
REQ-017 full / empty  output  1 each  occupancy flags.
REQ-018 ovf_cnt  output  8  dropped-record counter, saturating at 255.
REQ-019 stopped  output  1  high in STOPPED state.

Function
REQ-020 Record layout: [15:13] seq, [12] kind (0 reg, 1 mem), [11:8] PC, [7:4] dest, [3:0] data.
REQ-021 Reg record: dest = {2'b00, addrRz}, data = outDataMux; mem record: dest = aluResult, data = Ry.
REQ-022 A capture event is a rising edge in RUN with RegWrite or MemWrite high; at most one record per edge.
REQ-023 RegWrite and MemWrite both high: a mem record only is produced.
REQ-024 seq is a 3-bit counter, incrementing by 1 (wrapping 7->0) on every capture event, including dropped ones, so consumers detect gaps.
REQ-025 FSM states IDLE, RUN, STOPPED: IDLE->RUN when enable=1; RUN->IDLE when enable=0; RUN->STOPPED on drop when STOP_ON_OVF=1; STOPPED->IDLE when enable=0.
REQ-026 Events on the edge where enable first rises are not captured (capture starts the following edge).
REQ-027 First-word fall-through: a record pushed into an empty FIFO at edge N shows trace_valid=1 and its trace_data in the cycle after edge N.
REQ-028 Pop occurs on an edge with trace_valid=1 and trace_ready=1; trace_data is stable while trace_valid=1 and trace_ready=0.
REQ-029 Push while full with no pop: record dropped, ovf_cnt increments (saturates at 255), FIFO contents unchanged.
REQ-030 Push while full with a pop on the same edge: both accepted; count unchanged; no drop.
REQ-031 Push and pop on the same edge when not full: count unchanged.
REQ-032 Pointers wrap modulo DEPTH; full = (count==DEPTH), empty = (count==0).
REQ-033 FIFO draining continues in IDLE and STOPPED; only capture halts.

Reset
REQ-034 While reset=0: state IDLE; count=0; empty=1; full=0; trace_valid=0; trace_data=0; ovf_cnt=0; seq=0; stopped=0.
REQ-035 Reset asserted mid-operation discards all queued records without any handshake; capture resumes only via REQ-025 after release.

Structure
REQ-036 Shared package cpu_trace_pkg holds: record width 16, field bit positions, kind encodings, FSM state encodings, default DEPTH.
REQ-037 Storage and pointers live in sub-module trace_fifo_mem (push, pop, data in/out, count); cpu_trace_fifo holds the FSM, record formatting, seq and ovf_cnt.

Verification
REQ-038 Reset release, enable=1, then RegWrite=1, PC=3, addrRz=2, outDataMux=9 for one edge -> after one cycle trace_valid=1, trace_data=16'h0_3_2_9 pattern (seq0,kind0,PC3,dest2,data9), count=1.
REQ-039 MemWrite=1, aluResult=5, Ry=A, PC=7, with RegWrite=1 on the same edge -> single record, kind=1, dest=5, data=A; count +1.
REQ-040 trace_ready=0, 10 consecutive capture events, DEPTH=8 -> count=8, full=1, ovf_cnt=2, head seq=0; then drain -> seq 0..7 in order.
REQ-041 Full FIFO, trace_ready=1 and capture on the same edge -> count stays 8, ovf_cnt unchanged, new record at tail.
REQ-042 STOP_ON_OVF=1, overflow once -> stopped=1, later events ignored, seq frozen; enable=0 -> IDLE, stopped=0.
REQ-043 reset=0 asynchronously mid-stream with count=5 -> outputs take REQ-034 values before the next clock edge.
